// File: rtl/eth_frame_parser_if.sv
// Stream and header transaction interfaces shared by the Ethernet receive path.
// Only the signals enabled by the parameter set used in this path are carried.
interface AXIS_IF #(
    parameter int unsigned TDATA_WIDTH    = 8,
    parameter int unsigned TID_WIDTH      = 0,
    parameter int unsigned TDEST_WIDTH    = 0,
    parameter int unsigned TUSER_WIDTH    = 1,
    parameter bit          TKEEP_ENABLE   = 1'b0,
    parameter bit          TWAKEUP_ENABLE = 1'b0
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;

    modport Transmitter (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport Receiver    (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

interface ETH_HEADER_IF;
    logic        valid;
    logic        ready;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;

    modport Transmitter (output valid, output dest_mac, output src_mac, output eth_type, input ready);
    modport Receiver    (input valid, input dest_mac, input src_mac, input eth_type, output ready);
endinterface

// File: rtl/eth_frame_parser.sv
// Receive-side Ethernet framer: strips the 14-byte MAC header into a header
// transaction and forwards the remaining bytes as a byte-wide payload stream.
module eth_frame_parser (
    input  logic              clk,
    input  logic              reset,
    AXIS_IF.Receiver          mii_axis_if,
    ETH_HEADER_IF.Transmitter eth_header_out_if,
    AXIS_IF.Transmitter       eth_payload_out_if,
    output logic              busy,
    output logic              error_header_early_termination
);

    if (mii_axis_if.TDATA_WIDTH != 8 || mii_axis_if.TID_WIDTH != 0 ||
        mii_axis_if.TDEST_WIDTH != 0 || mii_axis_if.TUSER_WIDTH != 1 ||
        mii_axis_if.TKEEP_ENABLE != 1'b0 || mii_axis_if.TWAKEUP_ENABLE != 1'b0) begin : g_bad_mii_params
        $error("eth_frame_parser: mii_axis_if must be 8-bit data, 1-bit tuser, no id/dest/keep/wakeup");
    end

    if (eth_payload_out_if.TDATA_WIDTH != 8 || eth_payload_out_if.TID_WIDTH != 0 ||
        eth_payload_out_if.TDEST_WIDTH != 0 || eth_payload_out_if.TUSER_WIDTH != 1 ||
        eth_payload_out_if.TKEEP_ENABLE != 1'b0 || eth_payload_out_if.TWAKEUP_ENABLE != 1'b0) begin : g_bad_payload_params
        $error("eth_frame_parser: eth_payload_out_if must be 8-bit data, 1-bit tuser, no id/dest/keep/wakeup");
    end

    typedef enum logic [1:0] {
        S_HEADER,
        S_HDR_WAIT,
        S_PAYLOAD
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [111:0]   hdr_q, hdr_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic           mii_tready;
    logic           hdr_valid;
    logic           pay_tvalid;
    logic           mii_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HEADER;
            cnt_q   <= '0;
            hdr_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign mii_xfer = mii_axis_if.tvalid && mii_tready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        mii_tready = 1'b0;
        hdr_valid  = 1'b0;
        pay_tvalid = 1'b0;

        case (state_q)
            S_HEADER: begin
                mii_tready = !reset;
                if (mii_xfer) begin
                    // Shifting in MSB-first leaves byte 0 in dest_mac[47:40] after 14 beats.
                    hdr_d = {hdr_q[103:0], mii_axis_if.tdata};
                    if (mii_axis_if.tlast) begin
                        err_d  = 1'b1;
                        cnt_d  = '0;
                        busy_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        busy_d = 1'b1;
                        if (cnt_q == 4'd13) begin
                            state_d = S_HDR_WAIT;
                        end
                    end
                end
            end
            S_HDR_WAIT: begin
                hdr_valid = 1'b1;
                if (eth_header_out_if.ready) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                pay_tvalid = mii_axis_if.tvalid;
                mii_tready = eth_payload_out_if.tready;
                if (mii_xfer && mii_axis_if.tlast) begin
                    state_d = S_HEADER;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_HEADER;
                cnt_d   = '0;
            end
        endcase
    end

    assign mii_axis_if.tready          = mii_tready;
    assign eth_header_out_if.valid     = hdr_valid;
    assign eth_header_out_if.dest_mac  = hdr_q[111:64];
    assign eth_header_out_if.src_mac   = hdr_q[63:16];
    assign eth_header_out_if.eth_type  = hdr_q[15:0];
    assign eth_payload_out_if.tvalid   = pay_tvalid;
    assign eth_payload_out_if.tdata    = mii_axis_if.tdata;
    assign eth_payload_out_if.tlast    = mii_axis_if.tlast;
    assign eth_payload_out_if.tuser    = mii_axis_if.tuser;
    assign busy                        = busy_q;
    assign error_header_early_termination = err_q;

endmodule

// File: tb/tb_eth_frame_parser.sv
// Self-checking bench for eth_frame_parser: table of frame vectors plus
// hand-written reset and back-to-back sequences.
module tb_eth_frame_parser;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    AXIS_IF #(.TDATA_WIDTH(8), .TID_WIDTH(0), .TDEST_WIDTH(0), .TUSER_WIDTH(1),
              .TKEEP_ENABLE(1'b0), .TWAKEUP_ENABLE(1'b0)) mii_if ();
    AXIS_IF #(.TDATA_WIDTH(8), .TID_WIDTH(0), .TDEST_WIDTH(0), .TUSER_WIDTH(1),
              .TKEEP_ENABLE(1'b0), .TWAKEUP_ENABLE(1'b0)) pay_if ();
    ETH_HEADER_IF hdr_if ();

    eth_frame_parser dut (
        .clk                            (clk),
        .reset                          (reset),
        .mii_axis_if                    (mii_if),
        .eth_header_out_if              (hdr_if),
        .eth_payload_out_if             (pay_if),
        .busy                           (busy),
        .error_header_early_termination (err)
    );

    typedef struct {
        int          len;
        bit          bad_last;
        int          hdr_delay;
        bit          pay_rand;
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
        logic [7:0]  base;
        int          exp_err;
        int          exp_hdr;
        int          exp_pay;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   tx_d [$];
    bit           tx_l [$];
    bit           tx_u [$];
    logic [7:0]   exp_pay [$];
    logic [111:0] exp_hdr [$];
    logic [7:0]   pay_d [$];
    bit           pay_l [$];
    bit           pay_u [$];
    logic [111:0] hdr_q [$];
    int           hdr_cyc [$];
    int           hv_rise [$];
    int           err_cyc [$];
    int           acc_cyc [$];
    logic         busy_hist [int];
    int           bp_viol;
    int           first_pay_cyc;
    int           cyc = 0;
    bit           mii_acc;
    int           hold_left;
    bit           hv_prev = 1'b0;
    bit           hv_hold_prev = 1'b0;
    logic [111:0] prev_fields;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample at negedge (stable inputs for the coming edge), then move to just after posedge.
    task automatic cycle();
        logic [111:0] f;
        @(negedge clk);
        cyc++;
        f = {hdr_if.dest_mac, hdr_if.src_mac, hdr_if.eth_type};
        mii_acc = mii_if.tvalid && mii_if.tready;
        busy_hist[cyc] = busy;
        if (pay_if.tvalid && pay_if.tready) begin
            pay_d.push_back(pay_if.tdata);
            pay_l.push_back(pay_if.tlast);
            pay_u.push_back(pay_if.tuser[0]);
            if (first_pay_cyc < 0) first_pay_cyc = cyc;
        end
        if (hdr_if.valid && !hv_prev) hv_rise.push_back(cyc);
        if (hdr_if.valid && hdr_if.ready) begin
            hdr_q.push_back(f);
            hdr_cyc.push_back(cyc);
        end
        if (hdr_if.valid) begin
            if (mii_if.tready || pay_if.tvalid) bp_viol++;
            if (hv_hold_prev && f !== prev_fields) bp_viol++;
            if (!hdr_if.ready && hold_left > 0) hold_left--;
        end
        if (err) err_cyc.push_back(cyc);
        hv_prev      = hdr_if.valid;
        hv_hold_prev = hdr_if.valid && !hdr_if.ready;
        prev_fields  = f;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        tx_d.delete(); tx_l.delete(); tx_u.delete();
        exp_pay.delete(); exp_hdr.delete();
        pay_d.delete(); pay_l.delete(); pay_u.delete();
        hdr_q.delete(); hdr_cyc.delete(); hv_rise.delete();
        err_cyc.delete(); acc_cyc.delete(); busy_hist.delete();
        bp_viol = 0;
        first_pay_cyc = -1;
    endtask

    task automatic build_frame(input vec_t v);
        logic [111:0] h;
        logic [7:0]   b;
        h = {v.dest, v.src, v.etype};
        for (int i = 0; i < v.len; i++) begin
            if (i < 14) b = h[111 - 8*i -: 8];
            else        b = v.base + 8'(i - 14);
            tx_d.push_back(b);
            tx_l.push_back(i == v.len - 1);
            tx_u.push_back((i == v.len - 1) && v.bad_last);
            if (i >= 14) exp_pay.push_back(b);
        end
        if (v.len > 14) exp_hdr.push_back(h);
    endtask

    task automatic send_stream(input bit pay_rand, input int limit);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        while (idx < limit && guard < 3000) begin
            mii_if.tvalid = 1'b1;
            mii_if.tdata  = tx_d[idx];
            mii_if.tlast  = tx_l[idx];
            mii_if.tuser  = tx_u[idx];
            hdr_if.ready  = (hold_left == 0);
            pay_if.tready = pay_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            if (mii_acc) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            guard++;
        end
        mii_if.tvalid = 1'b0;
        mii_if.tlast  = 1'b0;
        mii_if.tuser  = 1'b0;
        check("send_complete", idx, limit);
    endtask

    task automatic drain(input int n);
        hdr_if.ready  = 1'b1;
        pay_if.tready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_payload(input string tag);
        check($sformatf("%s pay_cnt", tag), pay_d.size(), exp_pay.size());
        for (int i = 0; i < pay_d.size() && i < exp_pay.size(); i++) begin
            check($sformatf("%s pay_data[%0d]", tag, i), pay_d[i], exp_pay[i]);
        end
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int last_acc;
        clear_capture();
        build_frame(v);
        hold_left = v.hdr_delay;
        send_stream(v.pay_rand, tx_d.size());
        drain(4);
        if (acc_cyc.size() != v.len) return;
        last_acc = acc_cyc[acc_cyc.size() - 1];

        check($sformatf("%s err_cnt", tag), err_cyc.size(), v.exp_err);
        if (v.exp_err > 0 && err_cyc.size() > 0)
            check($sformatf("%s err_timing", tag), err_cyc[0], last_acc + 1);
        check($sformatf("%s hdr_cnt", tag), hdr_q.size(), v.exp_hdr);
        if (v.exp_hdr > 0 && hdr_q.size() > 0 && hv_rise.size() > 0) begin
            check($sformatf("%s hdr_fields", tag), hdr_q[0], {v.dest, v.src, v.etype});
            check($sformatf("%s hdr_latency", tag), hv_rise[0], acc_cyc[13] + 1);
            check($sformatf("%s hdr_hold", tag), hdr_cyc[0], hv_rise[0] + v.hdr_delay);
            if (!v.pay_rand)
                check($sformatf("%s byte14_timing", tag), acc_cyc[14], hdr_cyc[0] + 1);
        end
        check($sformatf("%s hdr_wait_protocol", tag), bp_viol, 0);
        check_payload(tag);
        for (int i = 0; i < pay_l.size(); i++) begin
            check($sformatf("%s pay_last[%0d]", tag, i), pay_l[i], i == pay_l.size() - 1);
        end
        if (pay_u.size() > 0)
            check($sformatf("%s pay_tuser_final", tag), pay_u[pay_u.size() - 1], v.bad_last);
        if (v.len > 1)
            check($sformatf("%s busy_set", tag), busy_hist[acc_cyc[0] + 1], 1'b1);
        check($sformatf("%s busy_clear", tag), busy_hist[last_acc + 1], 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t b;
        int   first_acc;

        //          len bad dly rnd dest               src                type     base   err hdr pay
        vecs[0] = '{60, 0,  0,  0,  48'hFFFFFFFFFFFF, 48'h020000000001, 16'h0800, 8'h00, 0, 1, 46};
        vecs[1] = '{64, 0,  10, 0,  48'h001122334455, 48'h66778899AABB, 16'h86DD, 8'h80, 0, 1, 50};
        vecs[2] = '{10, 0,  0,  0,  48'hDEADBEEF0001, 48'h0A0B0C0D0E0F, 16'h0806, 8'h00, 1, 0, 0};
        vecs[3] = '{60, 0,  0,  0,  48'h0A0B0C0D0E0F, 48'h102030405060, 16'h0806, 8'h10, 0, 1, 46};
        vecs[4] = '{34, 1,  0,  1,  48'h123456789ABC, 48'hCBA987654321, 16'h0800, 8'hC0, 0, 1, 20};
        vecs[5] = '{14, 0,  0,  0,  48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'hC1C2, 8'h00, 1, 0, 0};
        vecs[6] = '{15, 0,  0,  0,  48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h1234, 8'h77, 0, 1, 1};
        vecs[7] = '{1,  0,  0,  0,  48'hFEDCBA987654, 48'h000000000000, 16'h0000, 8'h00, 1, 0, 0};

        reset         = 1'b1;
        mii_if.tvalid = 1'b0;
        mii_if.tdata  = '0;
        mii_if.tlast  = 1'b0;
        mii_if.tuser  = '0;
        hdr_if.ready  = 1'b1;
        pay_if.tready = 1'b1;
        hold_left     = 0;
        clear_capture();
        @(posedge clk);
        #1;
        cycle();
        cycle();

        check("reset mii_tready", mii_if.tready, 1'b0);
        check("reset hdr_valid", hdr_if.valid, 1'b0);
        check("reset pay_tvalid", pay_if.tvalid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset err", err, 1'b0);
        check("reset fields", {hdr_if.dest_mac, hdr_if.src_mac, hdr_if.eth_type}, 112'h0);
        reset = 1'b0;
        cycle();
        check("post_reset mii_tready", mii_if.tready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_vector(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the payload of a frame is streaming.
        clear_capture();
        build_frame(vecs[0]);
        hold_left = 0;
        send_stream(1'b0, 31);
        reset = 1'b1;
        cycle();
        check("midrst mii_tready", mii_if.tready, 1'b0);
        check("midrst hdr_valid", hdr_if.valid, 1'b0);
        check("midrst pay_tvalid", pay_if.tvalid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst err", err, 1'b0);
        check("midrst fields", {hdr_if.dest_mac, hdr_if.src_mac, hdr_if.eth_type}, 112'h0);
        reset = 1'b0;
        cycle();
        check("midrst mii_tready_after", mii_if.tready, 1'b1);
        run_vector(vecs[3], "after_midrst");

        // Three back-to-back 64-byte frames with no idle cycles between them.
        clear_capture();
        for (int k = 0; k < 3; k++) begin
            b       = vecs[1];
            b.hdr_delay = 0;
            b.dest  = 48'h00AA00BB0000 + 48'(k);
            b.src   = 48'h02CC00DD0000 + 48'(k * 16);
            b.etype = 16'h0800 + 16'(k);
            b.base  = 8'(k * 64);
            build_frame(b);
        end
        hold_left = 0;
        send_stream(1'b0, tx_d.size());
        drain(4);
        check("b2b hdr_cnt", hdr_q.size(), 3);
        for (int k = 0; k < 3 && k < hdr_q.size(); k++) begin
            check($sformatf("b2b hdr_fields[%0d]", k), hdr_q[k], exp_hdr[k]);
        end
        check_payload("b2b");
        check("b2b tlast_cnt", pay_l.sum() with (int'(item)), 3);
        check("b2b hdr_wait_protocol", bp_viol, 0);
        if (acc_cyc.size() == 192) begin
            first_acc = acc_cyc[0];
            check("b2b total_cycles", acc_cyc[191] - first_acc, 194);
            check("b2b frame2_start", acc_cyc[64], acc_cyc[63] + 1);
        end
        check("b2b err_cnt", err_cyc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_frame_parser.md
# eth_frame_parser

Receive-side Ethernet framer: consumes a byte-wide AXI-Stream of raw frames (MAC destination onward, no preamble or FCS) from the MII/MAC side. It strips the 14-byte Ethernet header into an ETH_HEADER_IF transaction and forwards the remaining bytes as a payload AXI-Stream. It is the receive-direction counterpart of the Ethernet header/payload transmit path and feeds the IP/ARP layers.

## Interface
- Parameters: none. Data path is fixed at 8 bits. Elaboration-time assertions require, on both AXIS_IF ports: TDATA_WIDTH=8, TID_WIDTH=0, TDEST_WIDTH=0, TUSER_WIDTH=1, TKEEP_ENABLE=0, TWAKEUP_ENABLE=0.
- clk  input  1  single clock for all logic
- reset  input  1  synchronous, active-high reset
- mii_axis_if  AXIS_IF.Receiver  8-bit  raw frame stream. tuser=1 on the tlast beat marks a bad frame.
- eth_header_out_if  ETH_HEADER_IF.Transmitter  valid/ready, dest_mac[47:0], src_mac[47:0], eth_type[15:0]
- eth_payload_out_if  AXIS_IF.Transmitter  8-bit  payload bytes following the header
- busy  output  1  frame in progress
- error_header_early_termination  output  1  one-cycle pulse when a frame ends before any payload byte

## Operation
- States:
  - HEADER: collect bytes 0..13.
  - HDR_WAIT: header presented, waiting for ready.
  - PAYLOAD: forward payload bytes.
- 4-bit byte counter, 0..13. It is cleared on entering HEADER.
- Header assembly, MSB first:
  - byte 0 lands in dest_mac[47:40]; byte 5 in dest_mac[7:0]
  - bytes 6..11 land in src_mac[47:0]
  - byte 12 lands in eth_type[15:8]; byte 13 in eth_type[7:0]
- HEADER:
  - mii tready=1.
  - Each accepted beat stores its byte and increments the counter.
  - Beat accepted with tlast at counter 0..13 (frame ≤14 bytes): discard the frame, pulse error for 1 cycle, clear the counter, stay in HEADER, no header valid.
  - Beat accepted at counter 13 without tlast: go to HDR_WAIT. The header fields are already registered.
- HDR_WAIT:
  - header valid=1; mii tready=0.
  - Fields stay stable until valid&ready.
  - On valid&ready: valid goes to 0, go to PAYLOAD.
- PAYLOAD is a combinational pass-through:
  - payload tdata/tlast/tuser = mii tdata/tlast/tuser
  - payload tvalid = mii tvalid
  - mii tready = payload tready
  - On an accepted beat with tlast: go to HEADER.
  - tuser passes through unmodified. The parser never drops payload because of tuser.
- busy:
  - Set on the first accepted header byte.
  - Cleared on the cycle after the payload tlast transfer, or after an early-termination discard.
- Outside their owning state, payload tvalid and header valid are 0.

## Timing
- Reset values:
  - state HEADER, counter 0, header valid 0
  - dest_mac, src_mac, eth_type all 0
  - payload tvalid 0, busy 0, error 0
  - mii tready 0 while reset is high, 1 on the first cycle after reset deasserts.
- Header latency: header valid rises the cycle after byte 13 is accepted.
- Minimum header gap: 1 cycle (HDR_WAIT) when header ready is already high. Byte 14 can then transfer 2 cycles after byte 13.
- Payload latency: 0 cycles, combinational. Throughput is 1 byte per cycle with no bubbles.
- Back-to-back frames: byte 0 of the next frame may be accepted the cycle after the previous tlast transfer.
- The error pulse is registered and asserts the cycle after the offending tlast beat.
- Reset mid-frame: on the next edge all state and outputs return to their reset values. The partial frame is lost, and the next byte accepted is treated as byte 0.
- Handshake: header valid and payload tvalid never deassert without a transfer, except on reset.

## Test plan
- Nominal 60-byte frame, all readies high:
  - stimulus: dest FF:FF:FF:FF:FF:FF, src 02:00:00:00:00:01, type 0x0800, payload bytes 0x00..0x2D
  - response: header valid 1 cycle after byte 13 with exact fields; 46 payload beats 0x00..0x2D, tlast on 0x2D; busy low the cycle after.
- Header backpressure: header ready low for 10 cycles after valid.
  - Header fields stay stable and mii tready stays 0 throughout.
  - No payload beat appears before the header handshake.
- Early termination: 10-byte frame with tlast on byte 9.
  - error pulses exactly 1 cycle and no header valid appears.
  - The following nominal frame parses correctly.
- Payload backpressure and tuser:
  - stimulus: random payload tready, tuser=1 on the last beat of a 20-byte payload
  - response: all 20 bytes in order with no duplication; tlast=1 and tuser=1 on the final beat.
- Reset asserted mid-payload (byte 30):
  - All outputs are at reset values one cycle later.
  - The next frame after reset is parsed from byte 0 with correct fields.
- Back-to-back frames: three 64-byte frames with zero idle cycles.
  - Three header transactions, three payload streams of 50 bytes each.
  - The only bubble per frame is the single HDR_WAIT cycle.
